// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider: FSM state type, its encoding
// and the iteration-counter width helper.
package divider_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_CALC = 2'd1;
  localparam logic [1:0] ENC_FIX  = 2'd2;
  localparam logic [1:0] ENC_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_CALC = ENC_CALC,
    ST_FIX  = ENC_FIX,
    ST_DONE = ENC_DONE
  } div_state_e;

  // Bits needed to count n iterations down to one.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int W = 8
) (
  input  logic [W:0] rem_in,
  input  logic [W:0] div_in,
  input  logic       bit_in,
  output logic [W:0] rem_out,
  output logic       q_bit
);

  logic [W+1:0] shifted;
  logic [W:0]   trial;

  // The difference is only kept when it is smaller than the divisor, so the
  // W+1-bit modular subtraction is exact in that case.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, div_in});
    trial   = shifted[W:0] - div_in;
    rem_out = q_bit ? trial : shifted[W:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with clock enable,
// divide-by-zero detection and truncate-toward-zero sign correction.
module seq_divider
  import divider_pkg::*;
#(
  parameter int C_NUM_BITS = 8
) (
  input  logic                  CK,
  input  logic                  R,
  input  logic                  E,
  input  logic                  START,
  input  logic                  SIGNED,
  input  logic [C_NUM_BITS-1:0] A,
  input  logic [C_NUM_BITS-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [C_NUM_BITS-1:0] Q,
  output logic [C_NUM_BITS-1:0] REM,
  output logic                  DZ
);

  localparam int N  = C_NUM_BITS;
  localparam int CW = count_width(N);
  localparam logic [N-1:0] ONE = N'(1);

  div_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N:0]     prem_q, prem_d;
  logic [N:0]     dvsr_q, dvsr_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dz_q, dz_d;

  logic [N:0]     step_rem;
  logic           step_bit;
  logic [N-1:0]   mag_a, mag_b;
  logic           accept;

  // acc_q starts as |A| and fills with quotient bits as the dividend shifts out.
  div_step #(.W(N)) u_step (
    .rem_in  (prem_q),
    .div_in  (dvsr_q),
    .bit_in  (acc_q[N-1]),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    prem_d  = prem_q;
    dvsr_d  = dvsr_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    // An N-bit unsigned magnitude represents |most negative| exactly.
    mag_a  = (SIGNED && A[N-1]) ? (~A + ONE) : A;
    mag_b  = (SIGNED && B[N-1]) ? (~B + ONE) : B;
    accept = E && START && (state_q == ST_IDLE || state_q == ST_DONE);

    if (accept) begin
      if (B == '0) begin
        quot_d  = '1;
        rem_d   = A;
        dz_d    = 1'b1;
        state_d = ST_DONE;
      end else begin
        acc_d   = mag_a;
        prem_d  = '0;
        dvsr_d  = {1'b0, mag_b};
        sa_d    = SIGNED & A[N-1];
        sb_d    = SIGNED & B[N-1];
        cnt_d   = CW'(N);
        dz_d    = 1'b0;
        state_d = ST_CALC;
      end
    end else if (E) begin
      unique case (state_q)
        ST_CALC: begin
          prem_d = step_rem;
          acc_d  = {acc_q[N-2:0], step_bit};
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          quot_d  = (sa_q ^ sb_q) ? (~acc_q + ONE) : acc_q;
          rem_d   = sa_q ? (~prem_q[N-1:0] + ONE) : prem_q[N-1:0];
          state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      prem_q  <= '0;
      dvsr_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prem_q  <= prem_d;
      dvsr_q  <= dvsr_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign BUSY = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign DONE = (state_q == ST_DONE);
  assign Q    = quot_q;
  assign REM  = rem_q;
  assign DZ   = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed corner cases with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int N = 8;

  logic         CK = 1'b0;
  logic         R, E, START, SIGNED;
  logic [N-1:0] A, B;
  logic         BUSY, DONE, DZ;
  logic [N-1:0] Q, REM;

  seq_divider #(.C_NUM_BITS(N)) dut (
    .CK(CK), .R(R), .E(E), .START(START), .SIGNED(SIGNED),
    .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .Q(Q), .REM(REM), .DZ(DZ)
  );

  always #5 CK = ~CK;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain integer division, truncating toward zero.
  function automatic void ref_div(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r);
    longint ai, bi, qi, ri;
    if (s) begin
      ai = longint'($signed(a));
      bi = longint'($signed(b));
    end else begin
      ai = longint'(a);
      bi = longint'(b);
    end
    qi = ai / bi;
    ri = ai % bi;
    q  = qi[N-1:0];
    r  = ri[N-1:0];
  endfunction

  // Transaction model: phase 0 idle, 1 working, 2 result presented.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [N-1:0] m_q = '0, m_rem = '0, p_q = '0, p_rem = '0;
  logic         m_dz = 1'b0;

  always @(posedge CK or posedge R) begin
    if (R) begin
      m_phase = 0; m_left = 0; m_q = '0; m_rem = '0; m_dz = 1'b0;
    end else if (E) begin
      if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 2; m_q = p_q; m_rem = p_rem;
        end
      end else if (START) begin
        if (B == '0) begin
          m_phase = 2; m_q = '1; m_rem = A; m_dz = 1'b1;
        end else begin
          m_phase = 1; m_left = N + 1; m_dz = 1'b0;
          ref_div(SIGNED, A, B, p_q, p_rem);
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  always @(negedge CK) begin
    if (chk_en) begin
      check("cyc_busy", 64'(BUSY), 64'(m_phase == 1));
      check("cyc_done", 64'(DONE), 64'(m_phase == 2));
      check("cyc_q",    64'(Q),    64'(m_q));
      check("cyc_rem",  64'(REM),  64'(m_rem));
      check("cyc_dz",   64'(DZ),   64'(m_dz));
    end
  end

  task automatic issue(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
    @(posedge CK); #1;
    E = 1'b1; START = 1'b1; SIGNED = s; A = a; B = b;
    @(posedge CK); #1;
    START = 1'b0;
  endtask

  // Counts edges (sampling edge = 1) until DONE is seen, bounded by limit.
  task automatic wait_done(input int first, input int limit, output int edges);
    edges = first;
    while (DONE !== 1'b1 && edges < limit) begin
      @(posedge CK); #1;
      edges++;
    end
  endtask

  function automatic logic [N-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 8'h80;
      2:       return 8'hFF;
      3:       return 8'h01;
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           edges;
    int           seen;
    logic [N-1:0] pq, pr;

    R = 1'b1; E = 1'b0; START = 1'b0; SIGNED = 1'b0; A = '0; B = '0;

    ref_div(1'b0, 8'd100, 8'd7, pq, pr);
    check("model_u100_7", 64'({pq, pr}), 64'(16'h0E02));
    ref_div(1'b1, 8'h9C, 8'h07, pq, pr);
    check("model_s-100_7", 64'({pq, pr}), 64'(16'hF2FE));
    ref_div(1'b1, 8'h80, 8'hFF, pq, pr);
    check("model_ovf", 64'({pq, pr}), 64'(16'h8000));

    repeat (2) @(posedge CK);
    #1;
    check("rst_busy", 64'(BUSY), 64'(0));
    check("rst_done", 64'(DONE), 64'(0));
    check("rst_q",    64'(Q),    64'(0));
    check("rst_rem",  64'(REM),  64'(0));
    check("rst_dz",   64'(DZ),   64'(0));
    R = 1'b0; E = 1'b1; chk_en = 1'b1;

    issue(1'b0, 8'd100, 8'd7);
    wait_done(1, 40, edges);
    check("u100_7_lat", 64'(edges), 64'(10));
    check("u100_7_q",   64'(Q),     64'(14));
    check("u100_7_rem", 64'(REM),   64'(2));
    check("u100_7_dz",  64'(DZ),    64'(0));

    issue(1'b1, 8'h9C, 8'h07);
    wait_done(1, 40, edges);
    check("s-100_7_lat", 64'(edges), 64'(10));
    check("s-100_7_q",   64'(Q),     64'(8'hF2));
    check("s-100_7_rem", 64'(REM),   64'(8'hFE));

    issue(1'b0, 8'h55, 8'h00);
    wait_done(1, 40, edges);
    check("dz_lat", 64'(edges), 64'(1));
    check("dz_flag", 64'(DZ),   64'(1));
    check("dz_q",    64'(Q),    64'(8'hFF));
    check("dz_rem",  64'(REM),  64'(8'h55));
    @(posedge CK); #1;
    check("dz_done_pulse", 64'(DONE), 64'(0));

    issue(1'b1, 8'h80, 8'hFF);
    wait_done(1, 40, edges);
    check("ovf_q",   64'(Q),   64'(8'h80));
    check("ovf_rem", 64'(REM), 64'(8'h00));
    check("ovf_dz",  64'(DZ),  64'(0));

    issue(1'b0, 8'd100, 8'd7);
    E = 1'b0;
    repeat (3) begin @(posedge CK); #1; end
    E = 1'b1;
    @(posedge CK); #1;
    START = 1'b1; A = 8'd50; B = 8'd5;
    @(posedge CK); #1;
    START = 1'b0;
    wait_done(6, 40, edges);
    check("stall_lat", 64'(edges), 64'(13));
    check("stall_q",   64'(Q),     64'(14));
    check("stall_rem", 64'(REM),   64'(2));
    @(posedge CK); #1;
    check("stall_2nd_ignored", 64'({BUSY, DONE}), 64'(0));

    issue(1'b0, 8'd100, 8'd7);
    repeat (2) begin @(posedge CK); #1; end
    R = 1'b1;
    #1;
    check("abort_busy", 64'(BUSY), 64'(0));
    check("abort_done", 64'(DONE), 64'(0));
    check("abort_q",    64'(Q),    64'(0));
    check("abort_rem",  64'(REM),  64'(0));
    @(posedge CK); #1;
    R = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge CK); #1;
      if (DONE === 1'b1) seen++;
    end
    check("abort_no_done", 64'(seen), 64'(0));
    issue(1'b0, 8'd13, 8'd3);
    wait_done(1, 40, edges);
    check("u13_3_q",   64'(Q),   64'(4));
    check("u13_3_rem", 64'(REM), 64'(1));

    for (int i = 0; i < 1500; i++) begin
      @(posedge CK); #1;
      E      = ($urandom_range(0, 9) != 0);
      START  = ($urandom_range(0, 3) == 0);
      SIGNED = 1'($urandom_range(0, 1));
      A      = pick_operand();
      B      = pick_operand();
      R      = ($urandom_range(0, 299) == 0);
    end
    @(posedge CK); #1;
    R = 1'b0; START = 1'b0; E = 1'b1;
    repeat (N + 4) @(posedge CK);
    #1;
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
